// File: rtl/bit_subtractor_serial.sv
// bit_subtractor_serial
//   Bit-serial 4-bit subtractor for the switch/LED board. A debounced press of
//   the push button computes A - B, LSB first, with one bit per clock and a
//   registered borrow. The result stays on the LEDs until the next operation
//   completes.
//
//   State table
//     state   | meaning
//     S_IDLE  | waiting for a debounced start pulse
//     S_LOAD  | capture operands from i_switch, clear borrow/bit_cnt/res
//     S_SHIFT | one difference bit per cycle, 4 cycles total
//     S_DONE  | publish difference, borrow-out and valid to the LED registers
//
//   Ports
//     i_clk      : system clock, rising edge
//     i_rst_n    : synchronous active-low reset
//     i_switch   : A = i_switch[3:0], B = i_switch[7:4] (sampled in S_LOAD only)
//     i_push_btn : raw asynchronous start button, active-high
//     o_led      : [3:0] difference, [4] busy, [5] borrow-out, [6] valid, [7] 0
module bit_subtractor_serial #(
   parameter int DB_COUNT = 250000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_switch,
   input  logic       i_push_btn,
   output logic [7:0] o_led
);

   localparam int CW = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DB_COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic          r_sync1;
   logic          r_btn_s;
   logic          r_btn_db;
   logic          r_btn_db_d;
   logic [CW-1:0] r_db_cnt;
   logic          w_start;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_busy;
   logic          w_load;
   logic          w_shift;
   logic          w_done;

   logic [3:0]    r_a_sh;
   logic [3:0]    r_b_sh;
   logic          r_borrow;
   logic [1:0]    r_bit_cnt;
   logic [3:0]    r_res;
   logic [3:0]    r_diff;
   logic          r_borrow_out;
   logic          r_valid;
   logic          w_d;
   logic          w_borrow_nxt;

   // Button path: 2-flop synchronizer, then a counter that must see the
   // synchronized level differ for DB_COUNT consecutive cycles before the
   // debounced level follows it.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1    <= 1'b0;
         r_btn_s    <= 1'b0;
         r_btn_db   <= 1'b0;
         r_btn_db_d <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_sync1    <= i_push_btn;
         r_btn_s    <= r_sync1;
         r_btn_db_d <= r_btn_db;
         if (r_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_btn_s;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   // Rising edge of the debounced level; high in the first cycle btn_db is 1.
   assign w_start = r_btn_db & ~r_btn_db_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_SHIFT;
         S_SHIFT: if (r_bit_cnt == 2'd3) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy  = (r_state != S_IDLE);
      w_load  = (r_state == S_LOAD);
      w_shift = (r_state == S_SHIFT);
      w_done  = (r_state == S_DONE);
   end

   // One full-subtractor stage applied to the LSBs of the shift registers.
   assign w_d          = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
   assign w_borrow_nxt = (~r_a_sh[0] & r_b_sh[0]) |
                         (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_a_sh       <= '0;
         r_b_sh       <= '0;
         r_borrow     <= 1'b0;
         r_bit_cnt    <= '0;
         r_res        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
         r_valid      <= 1'b0;
      end else begin
         if (w_load) begin
            r_a_sh    <= i_switch[3:0];
            r_b_sh    <= i_switch[7:4];
            r_borrow  <= 1'b0;
            r_bit_cnt <= '0;
            r_res     <= '0;
         end
         if (w_shift) begin
            r_res     <= {w_d, r_res[3:1]};
            r_a_sh    <= {1'b0, r_a_sh[3:1]};
            r_b_sh    <= {1'b0, r_b_sh[3:1]};
            r_borrow  <= w_borrow_nxt;
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_done) begin
            r_diff       <= r_res;
            r_borrow_out <= r_borrow;
            r_valid      <= 1'b1;
         end
      end
   end

   assign o_led = {1'b0, r_valid, r_borrow_out, w_busy, r_diff};

endmodule

// File: doc/bit_subtractor_serial.md
# bit_subtractor_serial

Bit-serial 4-bit subtractor for the switch/LED board: computes A − B one bit per clock, LSB first, with a registered borrow. It is the inverse-direction companion to the ripple full-adder datapath and uses the same operand mapping: A on switch[3:0], B on switch[7:4], difference on led[3:0], borrow-out on led[5]. A debounced press of push_btn starts each operation, and results are held on the LEDs until the next operation completes.

## Interface
- DB_COUNT, default 250000: number of consecutive clk cycles the synchronized button must differ from the debounced level before the debounced level flips. Must be ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- switch  input  8  operands: A = switch[3:0], B = switch[7:4]. Asynchronous to clk, but only sampled in LOAD.
- push_btn  input  1  raw, bouncy, asynchronous start button, active-high.
- led  output  8  led[3:0] = difference, led[4] = busy, led[5] = borrow-out, led[6] = result valid, led[7] = constant 0.

## Operation
- Button path:
  - push_btn passes through a 2-flop synchronizer to give btn_s.
  - The debounce counter clears whenever btn_s equals btn_db, and increments otherwise.
  - When the counter reaches DB_COUNT−1 while btn_s still differs, btn_db takes the value of btn_s and the counter clears.
  - start is a 1-cycle pulse on each 0→1 transition of btn_db.
- FSM states are IDLE, LOAD, SHIFT and DONE.
  - IDLE: if start is high, go to LOAD. Otherwise stay in IDLE.
  - LOAD: capture a_sh ← switch[3:0] and b_sh ← switch[7:4]. Clear borrow, bit_cnt and res. Go to SHIFT.
  - SHIFT, per cycle:
    - Compute d = a_sh[0] ^ b_sh[0] ^ borrow.
    - Compute borrow ← (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
    - Update res ← {d, res[3:1]}, and shift a_sh and b_sh right by one.
    - Increment bit_cnt. After the 4th SHIFT cycle (bit_cnt == 3) go to DONE.
  - DONE: led[3:0] ← res, led[5] ← borrow, led[6] ← 1. Go to IDLE.
- Arithmetic: the difference is (A − B) mod 16. Borrow-out is 1 exactly when A < B. There is no signed interpretation.
- start pulses that occur in any state other than IDLE are dropped; they are not queued.
- Switch changes after LOAD have no effect on the operation in progress.
- led[4] = 1 whenever the state is not IDLE. It is combinational from the state register.
- led[3:0], led[5] and led[6] are registers. They change only on the DONE edge and on reset.

## Timing
- Reset (rst_n = 0 at a rising edge) sets:
  - State to IDLE, and all shift registers, borrow and bit_cnt to 0.
  - Both synchronizer flops, btn_db and the debounce counter to 0.
  - All led bits to 0 from the following cycle onward.
- Button latency: a clean press reaches btn_db 2 + DB_COUNT cycles after push_btn rises. start is high in that same cycle.
- Operation latency, taking cycle 0 as the IDLE cycle where start is high:
  - Cycle 1 is LOAD, and switch is sampled at the end of cycle 1.
  - Cycles 2–5 are SHIFT.
  - Cycle 6 is DONE.
  - New results are visible from cycle 7.
- led[4] is high in cycles 1–6.
- Throughput: at most one operation per 7 cycles. A new start is accepted at the earliest in cycle 7.
- Reset asserted during LOAD, SHIFT or DONE: the operation is aborted, the partial result is discarded, and the LED registers clear.
- rst_n low and start in the same cycle: reset wins.
- Releasing the button generates no start. A release bounce shorter than DB_COUNT does not toggle btn_db.

## Test plan
Run all scenarios with DB_COUNT = 4.
- Reset: hold rst_n = 0 for 3 cycles with push_btn = 1 → led = 8'h00 throughout, with no start pulse and no busy.
- Basic press: switch = 8'h39 (A = 9, B = 3), clean press → led[4] is high for 6 cycles, then led = 8'h46 (diff 6, borrow 0, valid 1). The result appears exactly 7 cycles after the start pulse.
- Underflow: switch = 8'h93 (A = 3, B = 9) → led[3:0] = 4'hA, led[5] = 1, led = 8'h6A. Also switch = 8'h55 → led = 8'h40.
- Bounce filter:
  - push_btn toggling every 2 cycles for 20 cycles, then held high → exactly one operation.
  - A 3-cycle high glitch → no operation, and led stays unchanged.
- Busy behaviour: switch = 8'h10 (A = 0, B = 1), press, then change switch to 8'h0F during SHIFT and press again while busy. Required result is led = 8'h6F from the first operation only, with no second operation.
- Reset mid-operation: start an operation on 8'h39, pull rst_n low in the 2nd SHIFT cycle → led = 8'h00 on the next cycle and the state is IDLE. A subsequent press completes normally.
